// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO write-port arbiter: FSM state
// encoding and the width helpers for the beat counter and owner index.
package fifo_pkg;

    // Arbiter FSM states: IDLE searches for a requester, GRANT streams its beats.
    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } arb_state_e;

    // Beat counter must represent 0..BURST.
    function automatic int beat_cnt_width(input int burst);
        return $clog2(burst + 1);
    endfunction

    // Owner index width; never narrower than one bit.
    function automatic int owner_idx_width(input int nreq);
        return (nreq > 1) ? $clog2(nreq) : 1;
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Round-robin first-set search: returns the first requester with its bit
// set, starting at ptr and wrapping modulo NREQ, as a one-hot vector.
module rr_pick
    import fifo_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IW   = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic [NREQ-1:0] pick,
    output logic            any
);

    localparam int            IW1    = IW + 1;
    localparam logic [IW:0]   NREQ_W = IW1'(NREQ);

    logic [IW:0]   sum_s;
    logic [IW-1:0] idx_s;

    // Walk the requesters from ptr upward, wrapping, and keep the first hit.
    always_comb begin
        pick  = '0;
        any   = 1'b0;
        sum_s = '0;
        idx_s = '0;
        for (int i = 0; i < NREQ; i++) begin
            sum_s = {1'b0, ptr} + IW1'(i);
            if (sum_s >= NREQ_W) begin
                sum_s = sum_s - NREQ_W;
            end else begin
                sum_s = sum_s;
            end
            idx_s = sum_s[IW-1:0];
            if (!any && req[idx_s]) begin
                pick[idx_s] = 1'b1;
                any         = 1'b1;
            end else begin
                any = any;
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter multiplexing NREQ valid/ready sources onto a single
// FIFO write port. An owner keeps the port for up to BURST beats, stalls
// while the FIFO is full, and releases early when its valid drops.
module fifo_wr_arbiter
    import fifo_pkg::*;
#(
    parameter int DSIZE = 8,
    parameter int NREQ  = 4,
    parameter int BURST = 4
) (
    input  logic                  wclk,
    input  logic                  wrst_n,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ*DSIZE-1:0] req_data,
    output logic [NREQ-1:0]       req_ready,
    input  logic                  wfull,
    output logic                  winc,
    output logic [DSIZE-1:0]      wdata,
    output logic [NREQ-1:0]       grant
);

    localparam int              IW        = owner_idx_width(NREQ);
    localparam int              CW        = beat_cnt_width(BURST);
    localparam logic [IW-1:0]   LAST_IDX  = IW'(NREQ - 1);
    localparam logic [CW-1:0]   LAST_BEAT = CW'(BURST - 1);

    arb_state_e      state_r,    state_nxt_s;
    logic [IW-1:0]   owner_r,    owner_nxt_s;
    logic [IW-1:0]   rr_ptr_r,   rr_ptr_nxt_s;
    logic [CW-1:0]   beat_cnt_r, beat_cnt_nxt_s;
    logic [NREQ-1:0] grant_r,    grant_nxt_s;

    logic [NREQ-1:0] pick_oh_s;
    logic            pick_any_s;
    logic [IW-1:0]   pick_idx_s;
    logic [IW-1:0]   owner_inc_s;
    logic            owner_valid_s;
    logic            xfer_s;
    logic            last_beat_s;

    rr_pick #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_rr_pick (
        .req  (req_valid),
        .ptr  (rr_ptr_r),
        .pick (pick_oh_s),
        .any  (pick_any_s)
    );

    // Convert the one-hot pick into an owner index.
    always_comb begin
        pick_idx_s = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (pick_oh_s[i]) begin
                pick_idx_s = IW'(i);
            end else begin
                pick_idx_s = pick_idx_s;
            end
        end
    end

    // Owner-side handshake terms and the wrapped successor of the owner.
    always_comb begin
        owner_valid_s = 1'b0;
        if (state_r == ST_GRANT) begin
            owner_valid_s = req_valid[owner_r];
        end else begin
            owner_valid_s = 1'b0;
        end
        xfer_s      = owner_valid_s & ~wfull;
        last_beat_s = (beat_cnt_r == LAST_BEAT);
        if (owner_r == LAST_IDX) begin
            owner_inc_s = '0;
        end else begin
            owner_inc_s = owner_r + IW'(1);
        end
    end

    // Next-state logic: pick an owner in IDLE, count beats and release in GRANT.
    always_comb begin
        state_nxt_s    = state_r;
        owner_nxt_s    = owner_r;
        rr_ptr_nxt_s   = rr_ptr_r;
        beat_cnt_nxt_s = beat_cnt_r;
        grant_nxt_s    = grant_r;
        case (state_r)
            ST_IDLE: begin
                if (pick_any_s) begin
                    state_nxt_s    = ST_GRANT;
                    owner_nxt_s    = pick_idx_s;
                    grant_nxt_s    = pick_oh_s;
                    beat_cnt_nxt_s = '0;
                end else begin
                    grant_nxt_s = '0;
                end
            end
            ST_GRANT: begin
                // A missing owner beat ends the burst even if the FIFO is full:
                // there is nothing left to hold the port for.
                if (!owner_valid_s || (xfer_s && last_beat_s)) begin
                    state_nxt_s    = ST_IDLE;
                    rr_ptr_nxt_s   = owner_inc_s;
                    beat_cnt_nxt_s = '0;
                    grant_nxt_s    = '0;
                end else if (xfer_s) begin
                    beat_cnt_nxt_s = beat_cnt_r + CW'(1);
                end else begin
                    beat_cnt_nxt_s = beat_cnt_r;
                end
            end
            default: begin
                state_nxt_s    = ST_IDLE;
                owner_nxt_s    = '0;
                rr_ptr_nxt_s   = '0;
                beat_cnt_nxt_s = '0;
                grant_nxt_s    = '0;
            end
        endcase
    end

    // Arbiter state registers; reset abandons any burst in flight.
    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            state_r    <= ST_IDLE;
            owner_r    <= '0;
            rr_ptr_r   <= '0;
            beat_cnt_r <= '0;
            grant_r    <= '0;
        end else begin
            state_r    <= state_nxt_s;
            owner_r    <= owner_nxt_s;
            rr_ptr_r   <= rr_ptr_nxt_s;
            beat_cnt_r <= beat_cnt_nxt_s;
            grant_r    <= grant_nxt_s;
        end
    end

    // FIFO write port and ready steering; combinational so the FIFO sees
    // the owner's beat in the same cycle, gated off entirely outside GRANT.
    always_comb begin
        req_ready = '0;
        winc      = 1'b0;
        wdata     = '0;
        grant     = grant_r;
        if (state_r == ST_GRANT) begin
            req_ready = grant_r & {NREQ{~wfull}};
            winc      = xfer_s;
            wdata     = req_data[owner_r*DSIZE +: DSIZE];
        end else begin
            req_ready = '0;
            winc      = 1'b0;
            wdata     = '0;
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: round-robin order, burst length,
// FIFO-full stalls, early release, reset mid-burst and a write log check.
module tb_fifo_wr_arbiter;

    localparam int DSIZE = 8;
    localparam int NREQ  = 4;
    localparam int BURST = 4;

    logic                  wclk = 1'b0;
    logic                  wrst_n;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ*DSIZE-1:0] req_data;
    logic [NREQ-1:0]       req_ready;
    logic                  wfull;
    logic                  winc;
    logic [DSIZE-1:0]      wdata;
    logic [NREQ-1:0]       grant;

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0]      src_mem [NREQ][32];
    int              head    [NREQ];
    int              tail    [NREQ];
    logic [NREQ-1:0] en;
    logic [NREQ-1:0] fire = '0;

    logic [7:0] log_mem [64];
    int         log_n = 0;
    logic [7:0] exp_mem [64];
    int         exp_n = 0;

    fifo_wr_arbiter #(
        .DSIZE (DSIZE),
        .NREQ  (NREQ),
        .BURST (BURST)
    ) dut (
        .wclk      (wclk),
        .wrst_n    (wrst_n),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .wfull     (wfull),
        .winc      (winc),
        .wdata     (wdata),
        .grant     (grant)
    );

    always #5 wclk = ~wclk;

    // Record handshakes and FIFO writes midway between rising edges.
    always @(negedge wclk) begin
        fire <= req_valid & req_ready;
        if (winc) begin
            if (log_n < 64) log_mem[log_n] <= wdata;
            log_n <= log_n + 1;
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic push(input int i, input logic [7:0] d);
        src_mem[i][tail[i]] = d;
        tail[i] = tail[i] + 1;
    endtask

    task automatic expect_wr(input logic [7:0] d);
        exp_mem[exp_n] = d;
        exp_n = exp_n + 1;
    endtask

    task automatic clear_src();
        for (int i = 0; i < NREQ; i++) begin
            head[i] = 0;
            tail[i] = 0;
        end
    endtask

    task automatic drive();
        for (int i = 0; i < NREQ; i++) begin
            if (head[i] < tail[i]) begin
                req_valid[i] = en[i];
                req_data[i*DSIZE +: DSIZE] = src_mem[i][head[i]];
            end else begin
                req_valid[i] = 1'b0;
                req_data[i*DSIZE +: DSIZE] = '0;
            end
        end
    endtask

    task automatic tick();
        @(posedge wclk);
        #1;
        for (int i = 0; i < NREQ; i++) begin
            if (fire[i]) head[i] = head[i] + 1;
        end
        drive();
        #1;
    endtask

    initial begin
        logic [7:0] d;
        int         o;

        // ---------------- reset state
        clear_src();
        wrst_n    = 1'b0;
        wfull     = 1'b0;
        en        = '0;
        req_valid = '0;
        req_data  = '0;
        #2;
        chk("rst_grant", 32'(grant), 32'h0);
        chk("rst_ready", 32'(req_ready), 32'h0);
        chk("rst_winc",  32'(winc), 32'h0);
        chk("rst_wdata", 32'(wdata), 32'h0);
        repeat (2) @(posedge wclk);
        #1 wrst_n = 1'b1;
        #1;

        // ---------------- single requester, 6 beats
        for (int k = 0; k < 6; k++) push(0, 8'(8'hA0 + k));
        en = 4'b0001;
        drive();
        #1;
        chk("t1_idle_grant", 32'(grant), 32'h0);
        chk("t1_idle_winc",  32'(winc), 32'h0);
        tick();
        chk("t1_grant", 32'(grant), 32'h1);
        chk("t1_ready", 32'(req_ready), 32'h1);
        for (int b = 0; b < 4; b++) begin
            d = 8'(8'hA0 + b);
            chk("t1_winc",  32'(winc), 32'h1);
            chk("t1_wdata", 32'(wdata), 32'(d));
            expect_wr(d);
            tick();
        end
        chk("t1_gap_grant", 32'(grant), 32'h0);
        chk("t1_gap_winc",  32'(winc), 32'h0);
        chk("t1_gap_wdata", 32'(wdata), 32'h0);
        tick();
        chk("t1_b2_grant", 32'(grant), 32'h1);
        chk("t1_b2_wdata", 32'(wdata), 32'hA4);
        expect_wr(8'hA4);
        tick();
        chk("t1_b2_wdata", 32'(wdata), 32'hA5);
        expect_wr(8'hA5);
        tick();
        chk("t1_novalid_grant", 32'(grant), 32'h1);
        chk("t1_novalid_winc",  32'(winc), 32'h0);
        tick();
        chk("t1_release", 32'(grant), 32'h0);

        // ---------------- reset pulse in IDLE, then all requesters
        @(posedge wclk);
        #1 wrst_n = 1'b0;
        en = '0;
        clear_src();
        drive();
        @(posedge wclk);
        #1 wrst_n = 1'b1;
        #1;
        for (int i = 0; i < NREQ; i++) begin
            for (int k = 0; k < 8; k++) push(i, 8'(i * 16 + k));
        end
        en = 4'b1111;
        drive();
        #1;
        for (int g = 0; g < 5; g++) begin
            o = g % 4;
            tick();
            chk("t2_grant", 32'(grant), 32'(1 << o));
            for (int b = 0; b < 4; b++) begin
                d = 8'(o * 16 + (g / 4) * 4 + b);
                chk("t2_winc",  32'(winc), 32'h1);
                chk("t2_wdata", 32'(wdata), 32'(d));
                expect_wr(d);
                tick();
            end
            chk("t2_idle", 32'(grant), 32'h0);
        end
        en = '0;
        clear_src();
        drive();
        #1;
        tick();
        chk("t2_stay_idle", 32'(grant), 32'h0);

        // ---------------- FIFO full for 5 cycles during requester 2
        for (int k = 0; k < 4; k++) push(2, 8'(8'hC0 + k));
        en = 4'b0100;
        drive();
        #1;
        tick();
        chk("t3_grant", 32'(grant), 32'h4);
        chk("t3_wdata", 32'(wdata), 32'hC0);
        expect_wr(8'hC0);
        tick();
        chk("t3_wdata", 32'(wdata), 32'hC1);
        expect_wr(8'hC1);
        tick();
        wfull = 1'b1;
        #1;
        chk("t3_full_winc",  32'(winc), 32'h0);
        chk("t3_full_ready", 32'(req_ready), 32'h0);
        chk("t3_full_grant", 32'(grant), 32'h4);
        repeat (4) begin
            tick();
            chk("t3_full_winc",  32'(winc), 32'h0);
            chk("t3_full_ready", 32'(req_ready), 32'h0);
            chk("t3_full_grant", 32'(grant), 32'h4);
        end
        tick();
        wfull = 1'b0;
        #1;
        chk("t3_resume_winc",  32'(winc), 32'h1);
        chk("t3_resume_ready", 32'(req_ready), 32'h4);
        chk("t3_resume_wdata", 32'(wdata), 32'hC2);
        expect_wr(8'hC2);
        tick();
        chk("t3_last_wdata", 32'(wdata), 32'hC3);
        expect_wr(8'hC3);
        tick();
        chk("t3_release", 32'(grant), 32'h0);
        en = '0;
        clear_src();
        drive();
        #1;

        // ---------------- owner 1 drops valid after one beat
        push(1, 8'hD0);
        push(2, 8'hE0);
        push(2, 8'hE1);
        en = 4'b0110;
        drive();
        #1;
        tick();
        chk("t4_grant1", 32'(grant), 32'h2);
        chk("t4_wdata",  32'(wdata), 32'hD0);
        expect_wr(8'hD0);
        tick();
        chk("t4_drop_grant", 32'(grant), 32'h2);
        chk("t4_drop_winc",  32'(winc), 32'h0);
        tick();
        chk("t4_idle", 32'(grant), 32'h0);
        tick();
        chk("t4_grant2", 32'(grant), 32'h4);
        chk("t4_wdata",  32'(wdata), 32'hE0);
        expect_wr(8'hE0);
        tick();
        chk("t4_wdata", 32'(wdata), 32'hE1);
        expect_wr(8'hE1);
        tick();
        chk("t4_drop2_winc", 32'(winc), 32'h0);
        tick();
        chk("t4_idle2", 32'(grant), 32'h0);
        en = '0;
        clear_src();
        drive();
        #1;

        // ---------------- reset in the middle of requester 3's burst
        for (int k = 0; k < 4; k++) push(3, 8'(8'hF0 + k));
        en = 4'b1000;
        drive();
        #1;
        tick();
        chk("t5_grant3", 32'(grant), 32'h8);
        chk("t5_wdata",  32'(wdata), 32'hF0);
        expect_wr(8'hF0);
        tick();
        chk("t5_wdata", 32'(wdata), 32'hF1);
        wrst_n = 1'b0;
        #1;
        chk("t5_rst_grant", 32'(grant), 32'h0);
        chk("t5_rst_ready", 32'(req_ready), 32'h0);
        chk("t5_rst_winc",  32'(winc), 32'h0);
        chk("t5_rst_wdata", 32'(wdata), 32'h0);
        tick();
        wrst_n = 1'b1;
        push(0, 8'h50);
        push(1, 8'h51);
        push(2, 8'h52);
        en = 4'b1111;
        drive();
        #1;
        chk("t5_post_idle", 32'(grant), 32'h0);
        tick();
        chk("t5_post_grant", 32'(grant), 32'h1);
        chk("t5_post_wdata", 32'(wdata), 32'h50);
        expect_wr(8'h50);
        tick();

        // ---------------- write log: every beat once, in order
        chk("log_count", 32'(log_n), 32'(exp_n));
        for (int i = 0; i < exp_n; i++) begin
            chk("log_beat", 32'(log_mem[i]), 32'(exp_mem[i]));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/fifo_wr_arbiter.md
FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 The block SHALL have parameter DSIZE, default 8, meaning data word width, matching the FIFO write port.
REQ-002 The block SHALL have parameter NREQ, default 4, meaning number of requesters (2..8).
REQ-003 The block SHALL have parameter BURST, default 4, meaning maximum beats per grant (1..16).
REQ-004 The block SHALL have port wclk  input  1  meaning single write-domain clock, all logic on rising edge.
REQ-005 The block SHALL have port wrst_n  input  1  meaning asynchronous active-low reset.
REQ-006 The block SHALL have port req_valid  input  NREQ  meaning per-requester data valid.
REQ-007 The block SHALL have port req_data  input  NREQ*DSIZE  meaning requester i data in bits [i*DSIZE +: DSIZE].
REQ-008 The block SHALL have port req_ready  output  NREQ  meaning per-requester accept; beat transfers when valid & ready.
REQ-009 The block SHALL have port wfull  input  1  meaning FIFO full flag, write domain.
REQ-010 The block SHALL have port winc  output  1  meaning FIFO write enable.
REQ-011 The block SHALL have port wdata  output  DSIZE  meaning FIFO write data.
REQ-012 The block SHALL have port grant  output  NREQ  meaning one-hot current owner, all-zero when idle.

Function
REQ-013 The FSM SHALL have states IDLE and GRANT.
REQ-014 In IDLE, when any req_valid is high, the FSM SHALL select the first requester with valid high, searching from rr_ptr upward modulo NREQ, and enter GRANT on the next edge with grant one-hot for that owner.
REQ-015 Arbitration latency SHALL be exactly one cycle from valid high in IDLE to grant asserted; no transfer occurs in IDLE.
REQ-016 In GRANT: req_ready[owner] = ~wfull; all other req_ready bits = 0.
REQ-017 In GRANT: winc = req_valid[owner] & ~wfull, combinationally.
REQ-018 wdata SHALL combinationally equal req_data slice of owner in GRANT, and 0 in IDLE.
REQ-019 The beat counter SHALL increment on each transfer and SHALL NOT advance while wfull is high or owner valid is low.
REQ-020 GRANT SHALL exit to IDLE on the edge where the BURST-th transfer completes.
REQ-021 GRANT SHALL exit to IDLE on the first edge where owner valid is low; no transfer occurs that cycle.
REQ-022 wfull high in GRANT SHALL hold the grant indefinitely with winc=0 and no release.
REQ-023 On every exit from GRANT, rr_ptr SHALL become (owner+1) mod NREQ and the beat counter SHALL clear.
REQ-024 Valid changes of non-owners during GRANT SHALL have no effect until the next IDLE.
REQ-025 No beat SHALL ever be written while wfull=1, and no beat SHALL be written twice or dropped.

Reset
REQ-026 Asserting wrst_n low SHALL immediately force state=IDLE, rr_ptr=0, beat count=0, grant=0, req_ready=0, winc=0, wdata=0.
REQ-027 Reset mid-burst SHALL abandon the burst without a partial-cycle winc; arbitration resumes from requester 0 after release.
REQ-028 Reset release SHALL be synchronous to wclk by the integrator; outputs SHALL hold reset values until the first edge after deassertion.

Structure
REQ-029 State encoding, BURST counter width ($clog2(BURST+1)) and owner index width ($clog2(NREQ)) SHALL live in shared package fifo_pkg.
REQ-030 The round-robin first-set search SHALL be one sub-module, rr_pick (NREQ-bit request, pointer in -> one-hot out, any flag).
REQ-031 The block SHALL drive the existing FIFO write port directly (winc/wdata/wfull) with no extra buffering.

Verification
REQ-032 Single requester: req_valid=0001, data 0xA0..0xA5, wfull=0 -> grant=0001 one cycle later, 4 beats A0..A3 written, IDLE one cycle, then A4,A5.
REQ-033 All valid (1111), BURST=4 -> grant order 0001,0010,0100,1000,0001; each burst exactly 4 winc pulses.
REQ-034 wfull raised after 2 beats of requester 2 for 5 cycles -> winc=0 and req_ready=0 for those 5 cycles, grant held, remaining 2 beats written after wfull drops.
REQ-035 Owner 1 drops valid after 1 beat -> next edge IDLE, rr_ptr=2, requester 2 granted next if valid.
REQ-036 wrst_n low mid-burst of requester 3 -> all outputs 0 immediately; after release with 1111 valid, grant=0001 first.
REQ-037 Scoreboard against real FIFO (DSIZE=8, depth 8) read side: every accepted beat read back once, in per-requester order.
